// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: VGA raster timing generator with built-in test patterns.
// Latency: syncs and colour reach the pins 2 pixel ticks after the stage-0 counters.
// Backpressure: none; free-running raster, pix_data must be valid one tick after pix_req.
// Ports: clk, reset (async, active-high); mode selects the pattern, latched once per frame;
//   pix_req/pix_x/pix_y ask for an external pixel, pix_data returns it {R,G,B};
//   frame_start pulses for one clk at the (0,0) wrap; VGA_* are the registered pin drivers.
module vga_timing_gen #(
  parameter int COLOR_BITS = 4,
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [3*COLOR_BITS-1:0] pix_data,
  output logic                    pix_req,
  output logic [9:0]              pix_x,
  output logic [9:0]              pix_y,
  output logic                    frame_start,
  output logic [COLOR_BITS-1:0]   VGA_RED,
  output logic [COLOR_BITS-1:0]   VGA_GREEN,
  output logic [COLOR_BITS-1:0]   VGA_BLUE,
  output logic                    VGA_HSYNC,
  output logic                    VGA_VSYNC
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Counters are 10 bits wide to match pix_x/pix_y; totals must not exceed 1024.
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COLOR_BITS-1:0] ONES = '1;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [9:0]            h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic                  act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [9:0]            x1_q, x1_d, y1_q, y1_d;
  logic [1:0]            mode_q, mode_d;
  logic                  frame_start_q, frame_start_d;
  logic [COLOR_BITS-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;

  logic                  ce, h_wrap, v_wrap;
  logic [2:0]            bar_idx;
  logic [COLOR_BITS-1:0] pat_r, pat_g, pat_b;

  always_comb begin
    ce     = (div_q == DIV_LAST);
    div_d  = ce ? '0 : div_q + DIV_W'(1);
    h_wrap = (h_cnt_q == H_LAST);
    v_wrap = (v_cnt_q == V_LAST);

    // Bar index floor(x*8/H_ACTIVE): count how many of the 7 bar edges x has passed.
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x1_q) * 8 >= k * H_ACTIVE) bar_idx = bar_idx + 3'd1;
    end

    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    unique case (mode_q)
      2'd0: {pat_r, pat_g, pat_b} = pix_data;
      2'd1: begin
        pat_r = bar_idx[2] ? ONES : '0;
        pat_g = bar_idx[1] ? ONES : '0;
        pat_b = bar_idx[0] ? ONES : '0;
      end
      2'd2: {pat_r, pat_g, pat_b} = {ONES, ONES, ONES};
      2'd3: if (x1_q[4] ^ y1_q[4]) {pat_r, pat_g, pat_b} = {ONES, ONES, ONES};
      default: ;
    endcase
    if (!act1_q) begin
      pat_r = '0;
      pat_g = '0;
      pat_b = '0;
    end

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    act1_d  = act1_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    mode_d  = mode_q;

    if (ce) begin
      // Stage 0: raster counters.
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      // Stage 1: region flags and coordinates of the current counter position.
      act1_d  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs1_d   = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
      vs1_d   = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
      x1_d    = h_cnt_q;
      y1_d    = v_cnt_q;
      // Stage 2: pins; syncs follow the same two-tick path as colour.
      red_d   = pat_r;
      green_d = pat_g;
      blue_d  = pat_b;
      hsync_d = hs1_q ? H_POL : ~H_POL;
      vsync_d = vs1_q ? V_POL : ~V_POL;
      // Mode only changes between frames so a frame is never split across patterns.
      if (h_wrap && v_wrap) mode_d = mode;
    end
    frame_start_d = ce & h_wrap & v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      act1_q        <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      x1_q          <= '0;
      y1_q          <= '0;
      mode_q        <= 2'd0;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      act1_q        <= act1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      mode_q        <= mode_d;
      frame_start_q <= frame_start_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign pix_req     = act1_q;
  assign pix_x       = x1_q;
  assign pix_y       = y1_q;
  assign frame_start = frame_start_q;
  assign VGA_RED     = red_q;
  assign VGA_GREEN   = green_q;
  assign VGA_BLUE    = blue_q;
  assign VGA_HSYNC   = hsync_q;
  assign VGA_VSYNC   = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;
  localparam int CB = 4;
  localparam int D  = 2;
  localparam int HA = 44, HF = 4, HS = 6, HB = 6;
  localparam int VA = 36, VF = 2, VS = 2, VB = 4;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FT  = HT * VT;
  localparam int SEG = FT * D;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      mode;
  logic [3*CB-1:0] pix_data;
  logic            pix_req;
  logic [9:0]      pix_x, pix_y;
  logic            frame_start;
  logic [CB-1:0]   VGA_RED, VGA_GREEN, VGA_BLUE;
  logic            VGA_HSYNC, VGA_VSYNC;

  int n;
  int errors;
  int checks;
  int cur_mode;
  int frame_mode [0:15];

  always #5 clk = ~clk;

  // External source returns a pattern built from the requested coordinates.
  assign pix_data = {pix_x[3:0], pix_y[3:0], 4'hA};

  vga_timing_gen #(
    .COLOR_BITS(CB), .CLK_DIV(D),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .pix_data(pix_data),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
    .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h clk_since_release=%0d", tag, obs, exp, n);
    end
  endtask

  // Colour of pixel (x,y) for a given pattern, straight from the pattern rules.
  function automatic logic [11:0] exp_colour(input int x, input int y, input int m);
    int r, g, b, i;
    r = 0; g = 0; b = 0;
    case (m)
      0: begin r = x % 16; g = y % 16; b = 10; end
      1: begin
        i = (x * 8) / HA;
        r = ((i / 4) % 2 == 1) ? 15 : 0;
        g = ((i / 2) % 2 == 1) ? 15 : 0;
        b = (i % 2 == 1) ? 15 : 0;
      end
      2: begin r = 15; g = 15; b = 15; end
      default: if (((x / 16) % 2) != ((y / 16) % 2)) begin r = 15; g = 15; b = 15; end
    endcase
    exp_colour = {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_pix_req"}, 32'(pix_req), 32'd0);
    chk({tag, "_pix_xy"}, 32'({pix_x, pix_y}), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_colour"}, 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'd0);
    chk({tag, "_hsync"}, 32'(VGA_HSYNC), 32'(!HP));
    chk({tag, "_vsync"}, 32'(VGA_VSYNC), 32'(!VP));
  endtask

  // Expected outputs after n clk edges since release: t ticks elapsed, stage 1
  // shows raster position t-1, the pins show position t-2.
  task automatic check_model();
    int t, p, h, v, k, m;
    logic [11:0] col;
    logic hs, vs, req, fs;
    t = n / D;
    if (t >= 1) begin
      p = (t - 1) % FT; h = p % HT; v = p / HT;
      req = (h < HA) && (v < VA);
      chk("pix_req", 32'(pix_req), 32'(req));
      if (req) chk("pix_xy", 32'({pix_x, pix_y}), 32'(h * 1024 + v));
    end else begin
      chk("pix_req0", 32'(pix_req), 32'd0);
      chk("pix_xy0", 32'({pix_x, pix_y}), 32'd0);
    end
    fs = (n > 0) && (n % D == 0) && ((n / D) % FT == 0);
    chk("frame_start", 32'(frame_start), 32'(fs));
    if (t >= 2) begin
      k = (t - 2) / FT; p = (t - 2) % FT; h = p % HT; v = p / HT;
      m = (k < 16) ? frame_mode[k] : 0;
      col = (h < HA && v < VA) ? exp_colour(h, v, m) : 12'h000;
      hs = (h >= HA + HF && h < HA + HF + HS) ? HP : !HP;
      vs = (v >= VA + VF && v < VA + VF + VS) ? VP : !VP;
    end else begin
      col = 12'h000; hs = !HP; vs = !VP;
    end
    chk("colour", 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'(col));
    chk("hsync", 32'(VGA_HSYNC), 32'(hs));
    chk("vsync", 32'(VGA_VSYNC), 32'(vs));
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    // Mode seen at the tick where the raster wraps belongs to the frame starting there.
    if (n % D == 0 && (n / D) % FT == 0 && (n / D) / FT < 16) frame_mode[(n / D) / FT] = cur_mode;
    @(negedge clk);
    check_model();
  endtask

  task automatic set_mode(input int m);
    cur_mode = m;
    mode = 2'(m);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset(tag);
    @(negedge clk);
    check_reset(tag);
    reset = 1'b0;
    n = 0;
    foreach (frame_mode[i]) frame_mode[i] = 0;
  endtask

  initial begin
    int off, base, rr;
    bit found;
    errors = 0; checks = 0; n = 0;
    foreach (frame_mode[i]) frame_mode[i] = 0;
    reset = 1'b1;
    set_mode(2);
    #3 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_model();

    // Five frames; each segment changes mode mid-frame, visible only from the next frame.
    base = int'($urandom_range(0, 3));
    for (int s = 0; s < 5; s++) begin
      off = int'($urandom_range(200, SEG - 400));
      for (int c = 0; c < SEG; c++) begin
        step();
        if (c == off) set_mode((s + base) % 4);
      end
    end

    // Reset landing inside an hsync pulse.
    found = 1'b0;
    for (int c = 0; c < 2 * HT * D && !found; c++) begin
      step();
      if (VGA_HSYNC === HP) found = 1'b1;
    end
    chk("hsync_seen", 32'(found), 32'd1);
    for (int c = 0; c < 3; c++) step();
    do_reset("rst_in_hsync");

    // Random mode changes plus a reset at a random point mid-frame.
    rr = int'($urandom_range(SEG / 3, SEG - 100));
    for (int c = 0; c < SEG + 3000; c++) begin
      step();
      if ($urandom_range(0, 299) == 0) set_mode(int'($urandom_range(0, 3)));
      if (c == rr) do_reset("rst_mid");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): COLOR_BITS, 4, bits per colour channel; CLK_DIV, 2, clk cycles per pixel tick (>=1); H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels; V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines; H_POL/V_POL, 0/0, sync active level (1 = active-high).
REQ-002 The block SHALL have one clock and an asynchronous active-high reset; ports (name, direction, width, meaning):
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 mode  in  2  pattern select: 0 external, 1 colour bars, 2 solid white, 3 checkerboard.
REQ-006 pix_data  in  3*COLOR_BITS  external pixel {R,G,B}, sampled one pixel tick after pix_req.
REQ-007 pix_req  out  1  stage-1 pixel lies in the active area.
REQ-008 pix_x  out  10  stage-1 column; pix_y  out  10  stage-1 row.
REQ-009 frame_start  out  1  one-clk pulse at the counter wrap to (0,0).
REQ-010 VGA_RED, VGA_GREEN, VGA_BLUE  out  COLOR_BITS each  registered colour.
REQ-011 VGA_HSYNC, VGA_VSYNC  out  1  registered syncs.

Function
REQ-012 A divider SHALL produce pixel tick ce high for one clk every CLK_DIV clks; the first ce SHALL occur on the CLK_DIV-th rising edge after reset release; with CLK_DIV=1, ce SHALL be constantly high.
REQ-013 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) on ce and wrap to 0; v_cnt SHALL advance on ce when h_cnt wraps, counting 0..V_TOTAL-1, and wrap to 0.
REQ-014 Regions: active h_cnt<H_ACTIVE; hsync for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vertical regions analogous on v_cnt.
REQ-015 Pipeline: stage 0 = counters; stage 1 = registered active, hsync, vsync, x, y (driving pix_req/pix_x/pix_y); stage 2 = output pins; each stage SHALL advance only on ce.
REQ-016 Syncs SHALL be delayed through both stages so that sync-to-colour alignment on the pins equals the stage-0 timing exactly (latency 2 pixel ticks).
REQ-017 Stage 2 SHALL drive all colour outputs to 0 when the stage-1 active flag is 0, regardless of mode.
REQ-018 Mode 0: stage 2 colour = pix_data sampled on the same ce.
REQ-019 Mode 1: 8 vertical bars, bar index i = floor(x*8/H_ACTIVE) via constant thresholds; R = all ones if i[2], G if i[1], B if i[0], else zero.
REQ-020 Mode 2: all channels all ones. Mode 3: white when x[4]^y[4] = 1, else black.
REQ-021 mode SHALL be latched into an internal register only on the ce where counters wrap to (0,0); mid-frame changes SHALL take effect at the next frame.
REQ-022 pix_x/pix_y SHALL hold the stage-1 counter values, valid only while pix_req = 1.
REQ-023 Sync output level SHALL be H_POL (resp. V_POL) inside the sync region and its inverse elsewhere.

Reset
REQ-024 On reset assertion, asynchronously: divider, h_cnt, v_cnt = 0; pix_req, frame_start = 0; pix_x, pix_y = 0; colours = 0; VGA_HSYNC = ~H_POL; VGA_VSYNC = ~V_POL; latched mode = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; after release, timing SHALL restart from (0,0) with no partial line.

Verification
REQ-026 Defaults, 50 MHz clk, reset pulse 100 ns -> VGA_HSYNC low 192 clk every 1600 clk; VGA_VSYNC low 3200 clk every 840000 clk.
REQ-027 Mode 1, defaults -> line colours 000,001,010,...,111 (R,G,B) in 80-pixel bars, then 0 during blanking; first coloured pixel 2 ticks after h_cnt=0.
REQ-028 Mode 0, pix_data = {x[3:0],y[3:0],4'hA} fed from pix_x/pix_y -> pins reproduce that value for every active pixel; zero in blanking.
REQ-029 Mode switched 0->2 at line 100 -> current frame unchanged; next frame all white; frame_start pulses once per 840000 clk.
REQ-030 H_POL=V_POL=1, CLK_DIV=1, small timing (H 8/2/2/2, V 4/1/1/1) -> active-high syncs; hsync period 14 clk; vsync period 98 clk.
REQ-031 Reset asserted during hsync pulse -> all outputs at reset values within the same clk; first ce CLK_DIV clks after release.
